mem_port_arbiter: RTL and testbench

Shares the single unified instruction/data memory between two requesters: the CPU datapath's memory port (port C) and a program loader/DMA port (port L).
- Each granted request becomes one memory transaction with a variable-latency ready handshake.
- A single ack pulse is returned to the requester, with read data registered on that ack.
- A timeout counter terminates transfers the memory never completes.
- The CPU controller holds its current state while cpu_stall is high.

---
 rtl/mem_port_arbiter_if.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for the two-requester memory arbiter. It carries the CPU port,
// the loader port, the memory side, and the status outputs.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // CPU port
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [DATA_W-1:0] c_rdata;
    logic              c_ack;
    logic              cpu_stall;
    // loader port
    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic [DATA_W-1:0] l_rdata;
    logic              l_ack;
    // memory side
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;
    // status
    logic              err;
    logic [1:0]        grant;

    // arbiter view
    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        output c_rdata, c_ack, cpu_stall,
        input  l_req, l_we, l_addr, l_wdata,
        output l_rdata, l_ack,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output err, grant
    );

    // requester and memory view
    modport master (
        output c_req, c_we, c_addr, c_wdata,
        input  c_rdata, c_ack, cpu_stall,
        output l_req, l_we, l_addr, l_wdata,
        input  l_rdata, l_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  err, grant
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one memory between the CPU port (C) and the
// loader port (L). Each grant runs one memory transaction. The transaction ends
// on mem_ready, or on a timeout if the memory never answers. The requester
// receives a single ack pulse, and read data is registered on that ack.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, XFER_C, XFER_L, DONE} state_t;

    // last_grant encoding: 0 = CPU, 1 = loader
    localparam logic LG_C = 1'b0;
    localparam logic LG_L = 1'b1;

    state_t             state_q, state_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]  c_rdata_q, c_rdata_d;
    logic [DATA_W-1:0]  l_rdata_q, l_rdata_d;
    logic               c_ack_q, c_ack_d;
    logic               l_ack_q, l_ack_d;
    logic               err_q, err_d;
    logic [1:0]         grant_q, grant_d;
    logic               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               xfer_l;
    logic               pick_c;

    // Register every piece of state. Reset takes priority, so it also removes any pending ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            c_rdata_q    <= '0;
            l_rdata_q    <= '0;
            c_ack_q      <= 1'b0;
            l_ack_q      <= 1'b0;
            err_q        <= 1'b0;
            grant_q      <= 2'b00;
            last_grant_q <= LG_L;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            c_rdata_q    <= c_rdata_d;
            l_rdata_q    <= l_rdata_d;
            c_ack_q      <= c_ack_d;
            l_ack_q      <= l_ack_d;
            err_q        <= err_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    // Compute the next state and the next value of every register.
    always_comb begin
        state_d      = state_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        c_rdata_d    = c_rdata_q;
        l_rdata_d    = l_rdata_q;
        c_ack_d      = 1'b0;
        l_ack_d      = 1'b0;
        err_d        = 1'b0;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        xfer_l       = (state_q == XFER_L);
        // When both ports request, the CPU wins only if the loader had the last grant.
        pick_c       = bus.c_req && (!bus.l_req || last_grant_q == LG_L);

        case (state_q)
            IDLE: begin
                if (pick_c) begin
                    state_d     = XFER_C;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.c_we;
                    mem_addr_d  = bus.c_addr;
                    mem_wdata_d = bus.c_wdata;
                    grant_d     = 2'b01;
                    cnt_d       = '0;
                end else if (bus.l_req) begin
                    state_d     = XFER_L;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.l_we;
                    mem_addr_d  = bus.l_addr;
                    mem_wdata_d = bus.l_wdata;
                    grant_d     = 2'b10;
                    cnt_d       = '0;
                end
            end
            XFER_C, XFER_L: begin
                // mem_ready takes precedence over the timeout when both happen in the same cycle.
                if (bus.mem_ready || cnt_q == CNT_LAST) begin
                    state_d      = DONE;
                    mem_en_d     = 1'b0;
                    err_d        = !bus.mem_ready;
                    last_grant_d = xfer_l ? LG_L : LG_C;
                    if (xfer_l) begin
                        l_ack_d = 1'b1;
                        if (!bus.mem_ready)
                            l_rdata_d = '0;
                        else if (!mem_we_q)
                            l_rdata_d = bus.mem_rdata;
                    end else begin
                        c_ack_d = 1'b1;
                        if (!bus.mem_ready)
                            c_rdata_d = '0;
                        else if (!mem_we_q)
                            c_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.c_rdata   = c_rdata_q;
    assign bus.l_rdata   = l_rdata_q;
    assign bus.c_ack     = c_ack_q;
    assign bus.l_ack     = l_ack_q;
    assign bus.err       = err_q;
    assign bus.grant     = grant_q;
    assign bus.cpu_stall = bus.c_req & ~c_ack_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Inputs change 1 ns after a rising edge,
// and outputs are sampled at that same point.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] order;
    int         n_ack;
    logic       early;

    initial begin
        reset = 1'b1;
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.l_req = 0; bus.l_we = 0; bus.l_addr = '0; bus.l_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;

        // reset state
        chk("rst_grant", bus.grant, 2'b00);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_acks", {bus.c_ack, bus.l_ack, bus.err}, 3'b000);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_rdata", {bus.c_rdata, bus.l_rdata}, 64'h0);

        // single read from zero-wait memory
        bus.mem_rdata = 32'h8C22_0004;
        bus.c_req = 1; bus.c_we = 0; bus.c_addr = 32'h40;
        tick();
        chk("rd_mem_en", bus.mem_en, 1);
        chk("rd_mem_addr", bus.mem_addr, 32'h40);
        chk("rd_grant", bus.grant, 2'b01);
        chk("rd_no_ack_yet", bus.c_ack, 0);
        chk("rd_stall", bus.cpu_stall, 1);
        tick();
        chk("rd_ack", bus.c_ack, 1);
        chk("rd_rdata", bus.c_rdata, 32'h8C22_0004);
        chk("rd_err", bus.err, 0);
        chk("rd_mem_en_drop", bus.mem_en, 0);
        chk("rd_stall_ack", bus.cpu_stall, 0);
        bus.c_req = 0;
        tick();
        chk("rd_ack_pulse", bus.c_ack, 0);
        chk("rd_grant_idle", bus.grant, 2'b00);

        // loader write with three wait states
        bus.mem_ready = 0;
        bus.l_req = 1; bus.l_we = 1; bus.l_addr = 32'h100; bus.l_wdata = 32'hDEAD_BEEF;
        tick();
        chk("wr_grant", bus.grant, 2'b10);
        for (int i = 0; i < 4; i++) begin
            chk("wr_en_hold", bus.mem_en, 1);
            chk("wr_we_hold", bus.mem_we, 1);
            chk("wr_wdata_hold", bus.mem_wdata, 32'hDEAD_BEEF);
            chk("wr_addr_hold", bus.mem_addr, 32'h100);
            chk("wr_no_ack", bus.l_ack, 0);
            bus.l_wdata = 32'h5555_0000 + i;
            if (i == 3) bus.mem_ready = 1;
            if (i < 3) tick();
        end
        tick();
        chk("wr_ack", bus.l_ack, 1);
        chk("wr_rdata_keep", bus.l_rdata, 0);
        chk("wr_err", bus.err, 0);
        bus.l_req = 0;
        tick();
        chk("wr_ack_pulse", bus.l_ack, 0);

        // contention: both ports keep requesting reads
        bus.mem_rdata = 32'hA5A5_0001;
        bus.c_we = 0; bus.l_we = 0;
        bus.c_req = 1; bus.l_req = 1;
        order = '0; n_ack = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            chk("ct_stall", bus.cpu_stall, !bus.c_ack);
            if (bus.c_ack && n_ack < 4) begin order = {order[5:0], 2'b01}; n_ack++; end
            if (bus.l_ack && n_ack < 4) begin order = {order[5:0], 2'b10}; n_ack++; end
        end
        chk("ct_order", order, 8'b01_10_01_10);
        chk("ct_count", n_ack, 4);
        chk("ct_rdata", {bus.c_rdata, bus.l_rdata}, {32'hA5A5_0001, 32'hA5A5_0001});
        bus.c_req = 0; bus.l_req = 0;
        tick();

        // timeout: the memory never answers
        bus.mem_ready = 0;
        bus.c_req = 1; bus.c_addr = 32'h200;
        tick();
        chk("to_grant", bus.grant, 2'b01);
        early = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.c_ack || bus.err) early = 1;
        end
        chk("to_no_early_ack", early, 0);
        tick();
        chk("to_ack", bus.c_ack, 1);
        chk("to_err", bus.err, 1);
        chk("to_rdata", bus.c_rdata, 0);
        bus.c_req = 0; bus.mem_ready = 1;
        tick();
        chk("to_err_pulse", bus.err, 0);
        bus.c_req = 1; bus.c_addr = 32'h44; bus.mem_rdata = 32'h1234_5678;
        tick(); tick();
        chk("to_next_ack", bus.c_ack, 1);
        chk("to_next_err", bus.err, 0);
        chk("to_next_rdata", bus.c_rdata, 32'h1234_5678);
        bus.c_req = 0;
        tick();

        // address change while the CPU transfer is in flight
        bus.mem_ready = 0;
        bus.c_req = 1; bus.c_addr = 32'h40;
        tick();
        chk("ac_addr0", bus.mem_addr, 32'h40);
        bus.c_addr = 32'h80;
        tick();
        chk("ac_addr1", bus.mem_addr, 32'h40);
        tick();
        chk("ac_addr2", bus.mem_addr, 32'h40);
        bus.mem_ready = 1;
        tick();
        chk("ac_ack", bus.c_ack, 1);
        chk("ac_addr_ack", bus.mem_addr, 32'h40);
        bus.c_req = 0;
        tick();

        // reset on the second cycle of a loader transfer
        bus.mem_ready = 0;
        bus.l_req = 1; bus.l_we = 0; bus.l_addr = 32'h300;
        tick();
        chk("rm_grant", bus.grant, 2'b10);
        tick();
        reset = 1; bus.mem_ready = 1;
        tick();
        reset = 0;
        chk("rm_mem_en", bus.mem_en, 0);
        chk("rm_no_ack", bus.l_ack, 0);
        chk("rm_grant_idle", bus.grant, 2'b00);
        bus.c_req = 1;
        tick();
        chk("rm_cpu_first", bus.grant, 2'b01);
        tick();
        chk("rm_cpu_ack", {bus.c_ack, bus.l_ack}, 2'b10);
        bus.c_req = 0; bus.l_req = 0;
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
